// File: rtl/imc_job_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | imc_job_sequencer                                                      |
// | Bus initiator that runs one IMC crossbar matrix-vector job: optional    |
// | weight program, vin write, settle, result readback.                     |
// | Option macro: IMC_SEQ_READBACK_CHECK_EN (read back every DATA write).   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module imc_job_sequencer #(
  parameter logic [31:0] BASE_ADDR     = 32'h400,
  parameter int          N_CELLS       = 64,
  parameter int          N_RESULTS     = 8,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      load_weights,
  input  logic [63:0]               vin,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [7:0]                w_data,
  output logic                      busy,
  output logic                      done,
  output logic [32*N_RESULTS-1:0]   results,
  output logic                      err,
  output logic                      req,
  output logic                      we,
  output logic [31:0]               addr,
  output logic [31:0]               wdata,
  input  logic                      gnt,
  input  logic                      rvalid,
  input  logic [31:0]               rdata
);

  localparam int RW = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1;

  localparam logic [31:0]   c_addr_data  = BASE_ADDR;
  localparam logic [31:0]   c_addr_addr  = BASE_ADDR + 32'h4;
  localparam logic [31:0]   c_addr_vlo   = BASE_ADDR + 32'h8;
  localparam logic [31:0]   c_addr_vhi   = BASE_ADDR + 32'hC;
  localparam logic [31:0]   c_addr_res   = BASE_ADDR + 32'h10;
  localparam logic [5:0]    c_idx_last   = 6'(N_CELLS - 1);
  localparam logic [RW-1:0] c_rd_last    = RW'(N_RESULTS - 1);
  localparam logic [15:0]   c_settle_last = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WFETCH = 4'd1,
    S_WDATA  = 4'd2,
    S_RBACK  = 4'd3,
    S_RBCAP  = 4'd4,
    S_WADDR  = 4'd5,
    S_VLO    = 4'd6,
    S_VHI    = 4'd7,
    S_SETTLE = 4'd8,
    S_RD     = 4'd9,
    S_RCAP   = 4'd10,
    S_DONE   = 4'd11
  } state_t;

  state_t                   state_q, state_d;
  logic [63:0]              vin_q, vin_d;
  logic [7:0]               wbyte_q, wbyte_d;
  logic [5:0]               idx_q, idx_d;
  logic [RW-1:0]            rd_idx_q, rd_idx_d;
  logic [15:0]              settle_q, settle_d;
  logic [32*N_RESULTS-1:0]  results_q, results_d;

  // The responder's rvalid also pulses after writes; capture timing is fixed instead.
  logic w_unused_rvalid;
  assign w_unused_rvalid = rvalid;

`ifdef IMC_SEQ_READBACK_CHECK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vin_q     <= '0;
      wbyte_q   <= '0;
      idx_q     <= '0;
      rd_idx_q  <= '0;
      settle_q  <= '0;
      results_q <= '0;
`ifdef IMC_SEQ_READBACK_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      vin_q     <= vin_d;
      wbyte_q   <= wbyte_d;
      idx_q     <= idx_d;
      rd_idx_q  <= rd_idx_d;
      settle_q  <= settle_d;
      results_q <= results_d;
`ifdef IMC_SEQ_READBACK_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    vin_d     = vin_q;
    wbyte_d   = wbyte_q;
    idx_d     = idx_q;
    rd_idx_d  = rd_idx_q;
    settle_d  = settle_q;
    results_d = results_q;
`ifdef IMC_SEQ_READBACK_CHECK_EN
    err_d     = err_q;
`endif
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    w_ready   = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vin_d     = vin;
          idx_d     = '0;
          rd_idx_d  = '0;
          results_d = '0;
`ifdef IMC_SEQ_READBACK_CHECK_EN
          err_d     = 1'b0;
`endif
          state_d   = load_weights ? S_WFETCH : S_VLO;
        end
      end
      S_WFETCH: begin
        w_ready = 1'b1;
        if (w_valid) begin
          wbyte_d = w_data;
          state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = c_addr_data;
        wdata = {24'b0, wbyte_q};
        if (gnt) begin
`ifdef IMC_SEQ_READBACK_CHECK_EN
          state_d = S_RBACK;
`else
          state_d = S_WADDR;
`endif
        end
      end
`ifdef IMC_SEQ_READBACK_CHECK_EN
      S_RBACK: begin
        req  = 1'b1;
        addr = c_addr_data;
        if (gnt) state_d = S_RBCAP;
      end
      S_RBCAP: begin
        // Mismatch is only flagged; the job carries on with the remaining cells.
        if (rdata[7:0] != wbyte_q) err_d = 1'b1;
        state_d = S_WADDR;
      end
`endif
      S_WADDR: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = c_addr_addr;
        wdata = {26'b0, idx_q};
        if (gnt) begin
          idx_d   = idx_q + 6'd1;
          state_d = (idx_q == c_idx_last) ? S_VLO : S_WFETCH;
        end
      end
      S_VLO: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = c_addr_vlo;
        wdata = vin_q[31:0];
        if (gnt) state_d = S_VHI;
      end
      S_VHI: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = c_addr_vhi;
        wdata = vin_q[63:32];
        if (gnt) begin
          settle_d = '0;
          state_d  = (SETTLE_CYCLES == 0) ? S_RD : S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q + 16'd1;
        if (settle_q == c_settle_last) state_d = S_RD;
      end
      S_RD: begin
        req  = 1'b1;
        addr = c_addr_res + (32'(rd_idx_q) << 2);
        if (gnt) state_d = S_RCAP;
      end
      S_RCAP: begin
        results_d[32*rd_idx_q +: 32] = rdata;
        rd_idx_d = rd_idx_q + RW'(1);
        state_d  = (rd_idx_q == c_rd_last) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign results = results_q;

endmodule
`default_nettype wire

// File: tb/tb_imc_job_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_imc_job_sequencer                                                   |
// | Randomized bench with a responder model and per-job expected traffic.   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_imc_job_sequencer;

  localparam logic [31:0] BASE = 32'h400;
`ifdef IMC_SEQ_READBACK_CHECK_EN
  localparam int PER_W = 5;
`else
  localparam int PER_W = 3;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         load_weights = 1'b0;
  logic [63:0]  vin = '0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic [7:0]   w_data = '0;
  logic         busy, done, err, req, we;
  logic [255:0] results;
  logic [31:0]  addr, wdata;
  logic         gnt;
  logic         rvalid = 1'b0;
  logic [31:0]  rdata = '0;

  logic         gnt_en = 1'b1;
  assign gnt = req & gnt_en;

  imc_job_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_weights(load_weights), .vin(vin),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .busy(busy), .done(done),
    .results(results), .err(err), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder / environment state
  logic [31:0] res_mem [0:7];
  logic [7:0]  wts [0:63];
  logic [7:0]  xbar [0:63];
  logic [31:0] data_reg = '0;
  int          data_wr_cnt = 0;
  int          corrupt_idx = -1;
  tx_t         obs_q[$];
  logic [7:0]  w_q[$];
  int          w_pos = 0;
  int          gap_at = -1;
  int          gap_left = 0;
  int          stall_vhi = 0;
  int          stall_rd3 = 0;
  bit          rand_mode = 1'b0;
  int          done_cnt = 0;

  logic        pend_rd = 1'b0;
  logic        pend_any = 1'b0;
  logic [31:0] pend_val = '0;
  logic        prev_stall = 1'b0;
  tx_t         prev_tx;
  tx_t         cur_tx;

  // Bus monitor and responder, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_rd = 1'b0; pend_any = 1'b0; prev_stall = 1'b0; rvalid = 1'b0;
      end else begin
        rvalid = pend_any;
        rdata  = pend_rd ? pend_val : $urandom();
        if (pend_rd) check_eq("capture_cycle_req", req, 1'b0);
        cur_tx = '{we, addr, we ? wdata : 32'h0};
        if (prev_stall) check_eq("stall_hold", {req, cur_tx}, {1'b1, prev_tx});
        if (w_ready && !w_valid) check_eq("starve_req", req, 1'b0);
        if (done) done_cnt++;
        if (w_valid && w_ready) begin
          void'(w_q.pop_front());
          w_pos++;
        end
        pend_rd = 1'b0; pend_any = 1'b0;
        if (req && gnt) begin
          obs_q.push_back(cur_tx);
          pend_any = 1'b1;
          if (we) begin
            if (addr == BASE) begin
              data_reg = wdata;
              data_wr_cnt++;
            end else if (addr == BASE + 32'h4) begin
              xbar[wdata[5:0]] = data_reg[7:0];
            end
          end else begin
            pend_rd = 1'b1;
            if (addr == BASE)
              pend_val = data_reg ^ (((data_wr_cnt - 1) == corrupt_idx) ? 32'h1 : 32'h0);
            else if (addr >= BASE + 32'h10 && addr < BASE + 32'h30 && addr[1:0] == 2'b00)
              pend_val = res_mem[(addr - BASE - 32'h10) >> 2];
            else
              pend_val = 32'hBAD0_0000;
          end
        end
        prev_stall = req && !gnt;
        prev_tx    = cur_tx;
      end
    end
  end

  // Grant generator: forced stalls on selected addresses, else full or random grant
  initial begin
    forever begin
      @(posedge clk); #1;
      if (req && addr == BASE + 32'hC && stall_vhi > 0) begin
        gnt_en = 1'b0; stall_vhi--;
      end else if (req && !we && addr == BASE + 32'h1C && stall_rd3 > 0) begin
        gnt_en = 1'b0; stall_rd3--;
      end else begin
        gnt_en = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Weight stream source
  initial begin
    forever begin
      @(posedge clk); #1;
      if (w_q.size() > 0 && w_pos == gap_at && gap_left > 0) begin
        w_valid = 1'b0;
        if (w_ready) gap_left--;
      end else if (w_q.size() > 0 && !(rand_mode && $urandom_range(0, 2) == 0)) begin
        w_valid = 1'b1;
        w_data  = w_q[0];
      end else begin
        w_valid = 1'b0;
      end
    end
  end

  task automatic run_job(input string name, input bit ld, input logic [63:0] v,
                         input bit rnd, input int exp_cycles, input bit poke);
    tx_t  exp_q[$];
    int   cyc;
    int   d0;
    int   n_obs;
    logic exp_err;
    for (int i = 0; i < 8; i++) res_mem[i] = $urandom();
    if (ld) begin
      for (int k = 0; k < 64; k++) begin
        exp_q.push_back('{1'b1, BASE, {24'b0, wts[k]}});
`ifdef IMC_SEQ_READBACK_CHECK_EN
        exp_q.push_back('{1'b0, BASE, 32'h0});
`endif
        exp_q.push_back('{1'b1, BASE + 32'h4, 32'(k)});
      end
    end
    exp_q.push_back('{1'b1, BASE + 32'h8, v[31:0]});
    exp_q.push_back('{1'b1, BASE + 32'hC, v[63:32]});
    for (int i = 0; i < 8; i++) exp_q.push_back('{1'b0, BASE + 32'h10 + 32'(4 * i), 32'h0});
`ifdef IMC_SEQ_READBACK_CHECK_EN
    exp_err = ld && corrupt_idx >= 0 && corrupt_idx < 64;
`else
    exp_err = 1'b0;
`endif

    @(posedge clk); #1;
    obs_q.delete();
    w_q.delete();
    if (ld) for (int k = 0; k < 64; k++) w_q.push_back(wts[k]);
    w_pos = 0;
    data_wr_cnt = 0;
    rand_mode = rnd;
    d0 = done_cnt;
    start = 1'b1; load_weights = ld; vin = v;
    @(posedge clk); #1;
    start = 1'b0; load_weights = $urandom_range(0, 1); vin = {$urandom(), $urandom()};
    cyc = 1;
    check_eq({name, "_busy"}, busy, 1'b1);
    check_eq({name, "_err_cleared"}, err, 1'b0);
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 8) begin start = 1'b1; load_weights = 1'b1; end
      if (poke && cyc == 9) start = 1'b0;
    end
    if (!done) begin
      check_eq({name, "_timeout"}, 1'b0, 1'b1);
    end else begin
      if (exp_cycles > 0) check_eq({name, "_done_cycle"}, 32'(cyc), 32'(exp_cycles));
      for (int i = 0; i < 8; i++)
        check_eq($sformatf("%s_result%0d", name, i), results[32*i +: 32], res_mem[i]);
      check_eq({name, "_err"}, err, exp_err);
    end
    @(posedge clk); #1;
    check_eq({name, "_done_pulse"}, {busy, done}, 2'b00);
    if (poke) repeat (30) @(posedge clk);
    #1;
    check_eq({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    n_obs = obs_q.size();
    check_eq({name, "_tx_count"}, 32'(n_obs), 32'(exp_q.size()));
    for (int i = 0; i < n_obs && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) check_eq($sformatf("%s_tx%0d", name, i), obs_q[i], exp_q[i]);
    n_checks++;
    if (ld) begin
      for (int k = 0; k < 64; k++)
        if (xbar[k] !== wts[k]) check_eq($sformatf("%s_cell%0d", name, k), xbar[k], wts[k]);
    end
    rand_mode = 1'b0;
  endtask

  task automatic reset_mid_read;
    int n;
    for (int i = 0; i < 8; i++) res_mem[i] = $urandom() | 32'h1;
    @(posedge clk); #1;
    start = 1'b1; load_weights = 1'b0; vin = {$urandom(), $urandom()};
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(req && !we && addr == BASE + 32'h20) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rst_reach_rd4", 32'(n < 200), 32'd1);
    check_eq("rst_partial_present", 32'(results[31:0] != 32'h0), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req", req, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_results", results, 256'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) xbar[k] = 8'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_bus", {req, we, addr, wdata}, 66'h0);
    check_eq("reset_status", {w_ready, busy, done, err}, 4'h0);
    check_eq("reset_results", results, 256'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Plain job, zero-wait bus
    run_job("t1", 1'b0, 64'h0102030405060708, 1'b0, 21, 1'b0);

    // Full weight program
    for (int k = 0; k < 64; k++) wts[k] = 8'(k) ^ 8'hA5;
    run_job("t2", 1'b1, {$urandom(), $urandom()}, 1'b0, 21 + 64 * PER_W, 1'b0);

    // Bus stalls on VHI and read 3
    stall_vhi = 5; stall_rd3 = 5;
    run_job("t3", 1'b0, {$urandom(), $urandom()}, 1'b0, 31, 1'b0);
    check_eq("t3_stalls_used", 32'(stall_vhi + stall_rd3), 32'd0);

    // Weight starvation before weight 10
    for (int k = 0; k < 64; k++) wts[k] = 8'($urandom());
    gap_at = 10; gap_left = 7;
    run_job("t4", 1'b1, {$urandom(), $urandom()}, 1'b0, 21 + 64 * PER_W + 7, 1'b0);
    check_eq("t4_gap_used", 32'(gap_left), 32'd0);
    gap_at = -1;

    // Reset mid-read, then a job with a start pulse while busy
    reset_mid_read();
    run_job("t5", 1'b0, {$urandom(), $urandom()}, 1'b0, 21, 1'b1);

`ifdef IMC_SEQ_READBACK_CHECK_EN
    for (int k = 0; k < 64; k++) wts[k] = 8'($urandom());
    corrupt_idx = 5;
    run_job("t6", 1'b1, {$urandom(), $urandom()}, 1'b0, 21 + 64 * PER_W, 1'b0);
    corrupt_idx = -1;
    run_job("t6_next", 1'b0, {$urandom(), $urandom()}, 1'b0, 21, 1'b0);
`endif

    // Randomized jobs with random grant and weight-valid timing
    for (int j = 0; j < 6; j++) begin
      bit ld;
      ld = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 64; k++) wts[k] = 8'($urandom());
      run_job($sformatf("rnd%0d", j), ld, {$urandom(), $urandom()}, 1'b1, 0, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
